huffman_axil_csr_slave: RTL and testbench

AXI4-Lite responder (slave) for the DARC Huffman IP control/status space, at the far end of the lite master that drives the S00_AXI register tests. It holds four fully read/write 32-bit registers at offsets 0x0, 0x4, 0x8 and 0xC, and exports their values plus per-register write pulses to the Huffman core. It adds byte-strobe merging, independent AW/W arrival, response backpressure and SLVERR decode for addresses beyond 0xC.

---
 rtl/huffman_axil_csr_slave_if.sv | 52 +++++
 rtl/huffman_axil_csr_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_huffman_axil_csr_slave.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/huffman_axil_csr_slave_if.sv
// AXI4-Lite bus bundle between the register-test master and the Huffman CSR block.
// Signal names follow the S00_AXI naming used by the master side.
interface huffman_axil_csr_slave_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/huffman_axil_csr_slave.sv
// AXI4-Lite responder holding the four Huffman control/status registers, with
// independent AW/W capture, byte-strobe merging and SLVERR above offset 0xC.
module huffman_axil_csr_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter logic [31:0] RESET_VAL          = 32'h0
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  huffman_axil_csr_slave_if.slave        s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0]  reg0_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]  reg1_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]  reg2_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]  reg3_out,
  output logic [3:0]                     reg_wr_pulse
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_COLLECT, W_RESP} wState_e;
  typedef enum logic {R_ADDR, R_DATA} rState_e;

  wState_e                       wState_q, wState_d;
  logic                          awReady_q, awReady_d;
  logic                          wReady_q, wReady_d;
  logic                          awHeld_q, awHeld_d;
  logic                          wHeld_q, wHeld_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awAddr_q, awAddr_d;
  logic [31:0]                   wData_q, wData_d;
  logic [3:0]                    wStrb_q, wStrb_d;
  logic                          bValid_q, bValid_d;
  logic [1:0]                    bResp_q, bResp_d;
  logic [3:0]                    pulse_q, pulse_d;
  logic [31:0]                   regs_q [4];
  logic [31:0]                   regs_d [4];

  rState_e                       rState_q, rState_d;
  logic                          arReady_q, arReady_d;
  logic                          rValid_q, rValid_d;
  logic [31:0]                   rData_q, rData_d;
  logic [1:0]                    rResp_q, rResp_d;

  logic                          awHs, wHs, arHs;
  logic                          wrInRange, rdInRange;
  logic [1:0]                    wrIdx, rdIdx;
  logic                          unused_ok;

  assign awHs      = s_axi.S_AXI_AWVALID && awReady_q;
  assign wHs       = s_axi.S_AXI_WVALID && wReady_q;
  assign arHs      = s_axi.S_AXI_ARVALID && arReady_q;
  assign wrInRange = (awAddr_q[C_S_AXI_ADDR_WIDTH-1:4] == '0);
  assign wrIdx     = awAddr_q[3:2];
  assign rdInRange = (s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4] == '0);
  assign rdIdx     = s_axi.S_AXI_ARADDR[3:2];
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       awAddr_q[1:0], s_axi.S_AXI_ARADDR[1:0]};

  // Readies reset low and rise on the first edge after release, since the
  // collect state asks for any channel not yet held.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wState_q  <= W_COLLECT;
      awReady_q <= 1'b0;
      wReady_q  <= 1'b0;
      awHeld_q  <= 1'b0;
      wHeld_q   <= 1'b0;
      awAddr_q  <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
      bValid_q  <= 1'b0;
      bResp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      regs_q    <= '{default: RESET_VAL};
      rState_q  <= R_ADDR;
      arReady_q <= 1'b0;
      rValid_q  <= 1'b0;
      rData_q   <= '0;
      rResp_q   <= RESP_OKAY;
    end else begin
      wState_q  <= wState_d;
      awReady_q <= awReady_d;
      wReady_q  <= wReady_d;
      awHeld_q  <= awHeld_d;
      wHeld_q   <= wHeld_d;
      awAddr_q  <= awAddr_d;
      wData_q   <= wData_d;
      wStrb_q   <= wStrb_d;
      bValid_q  <= bValid_d;
      bResp_q   <= bResp_d;
      pulse_q   <= pulse_d;
      regs_q    <= regs_d;
      rState_q  <= rState_d;
      arReady_q <= arReady_d;
      rValid_q  <= rValid_d;
      rData_q   <= rData_d;
      rResp_q   <= rResp_d;
    end
  end

  always_comb begin
    wState_d  = wState_q;
    awReady_d = awReady_q;
    wReady_d  = wReady_q;
    awHeld_d  = awHeld_q;
    wHeld_d   = wHeld_q;
    awAddr_d  = awAddr_q;
    wData_d   = wData_q;
    wStrb_d   = wStrb_q;
    bValid_d  = bValid_q;
    bResp_d   = bResp_q;
    pulse_d   = '0;
    regs_d    = regs_q;
    unique case (wState_q)
      W_COLLECT: begin
        if (awHeld_q && wHeld_q) begin
          awHeld_d  = 1'b0;
          wHeld_d   = 1'b0;
          awReady_d = 1'b0;
          wReady_d  = 1'b0;
          bValid_d  = 1'b1;
          wState_d  = W_RESP;
          // The pulse fires even for an all-zero strobe so the core sees the access.
          if (wrInRange) begin
            bResp_d        = RESP_OKAY;
            pulse_d[wrIdx] = 1'b1;
            for (int b = 0; b < 4; b++) begin
              if (wStrb_q[b]) begin
                regs_d[wrIdx][8*b +: 8] = wData_q[8*b +: 8];
              end
            end
          end else begin
            bResp_d = RESP_SLVERR;
          end
        end else begin
          if (awHs) begin
            awHeld_d = 1'b1;
            awAddr_d = s_axi.S_AXI_AWADDR;
          end
          if (wHs) begin
            wHeld_d = 1'b1;
            wData_d = s_axi.S_AXI_WDATA;
            wStrb_d = s_axi.S_AXI_WSTRB;
          end
          awReady_d = !awHeld_d;
          wReady_d  = !wHeld_d;
        end
      end
      W_RESP: begin
        awReady_d = 1'b0;
        wReady_d  = 1'b0;
        if (s_axi.S_AXI_BREADY) begin
          bValid_d  = 1'b0;
          awReady_d = 1'b1;
          wReady_d  = 1'b1;
          wState_d  = W_COLLECT;
        end
      end
    endcase
  end

  // Read data comes from the registered copy, so a same-edge commit is not visible.
  always_comb begin
    rState_d  = rState_q;
    arReady_d = arReady_q;
    rValid_d  = rValid_q;
    rData_d   = rData_q;
    rResp_d   = rResp_q;
    unique case (rState_q)
      R_ADDR: begin
        arReady_d = 1'b1;
        if (arHs) begin
          arReady_d = 1'b0;
          rValid_d  = 1'b1;
          rState_d  = R_DATA;
          if (rdInRange) begin
            rData_d = regs_q[rdIdx];
            rResp_d = RESP_OKAY;
          end else begin
            rData_d = '0;
            rResp_d = RESP_SLVERR;
          end
        end
      end
      R_DATA: begin
        arReady_d = 1'b0;
        if (s_axi.S_AXI_RREADY) begin
          rValid_d  = 1'b0;
          arReady_d = 1'b1;
          rState_d  = R_ADDR;
        end
      end
    endcase
  end

  assign s_axi.S_AXI_AWREADY = awReady_q;
  assign s_axi.S_AXI_WREADY  = wReady_q;
  assign s_axi.S_AXI_BVALID  = bValid_q;
  assign s_axi.S_AXI_BRESP   = bResp_q;
  assign s_axi.S_AXI_ARREADY = arReady_q;
  assign s_axi.S_AXI_RVALID  = rValid_q;
  assign s_axi.S_AXI_RDATA   = rData_q;
  assign s_axi.S_AXI_RRESP   = rResp_q;

  assign reg0_out     = regs_q[0];
  assign reg1_out     = regs_q[1];
  assign reg2_out     = regs_q[2];
  assign reg3_out     = regs_q[3];
  assign reg_wr_pulse = pulse_q;

  a_pulse_onehot: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
    $onehot0(reg_wr_pulse));
  a_b_stable: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
    bValid_q && !s_axi.S_AXI_BREADY |=> bValid_q && $stable(bResp_q));
  a_r_stable: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
    rValid_q && !s_axi.S_AXI_RREADY |=> rValid_q && $stable(rData_q) && $stable(rResp_q));
  a_single_write: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
    bValid_q |-> !awReady_q && !wReady_q);

endmodule

// File: tb/tb_huffman_axil_csr_slave.sv
// Scoreboard bench for huffman_axil_csr_slave: directed scenarios plus random
// reads/writes checked against a register-array reference model.
module tb_huffman_axil_csr_slave;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rExp_t;

  typedef struct {
    int          idx;
    logic [31:0] val;
  } pExp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  pulse;

  logic [1:0]  bQ [$];
  rExp_t       rQ [$];
  pExp_t       pQ [$];
  logic [31:0] model [4];
  int          assertCount = 0;
  int          failCount = 0;

  logic [1:0]  monB;
  rExp_t       monR;
  pExp_t       monP;

  always #5 clk = ~clk;

  huffman_axil_csr_slave_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) axi ();

  huffman_axil_csr_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .RESET_VAL(32'h0)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rstN),
    .s_axi(axi),
    .reg0_out(reg0),
    .reg1_out(reg1),
    .reg2_out(reg2),
    .reg3_out(reg3),
    .reg_wr_pulse(pulse)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] regOut(input int i);
    case (i)
      0: return reg0;
      1: return reg1;
      2: return reg2;
      default: return reg3;
    endcase
  endfunction

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("%s reg%0d", tag, i), regOut(i), model[i]);
  endtask

  // Reference model: a register file; offsets beyond 0xC answer SLVERR and change nothing.
  task automatic modelWrite(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    pExp_t p;
    int idx;
    if (addr[5:4] == 2'b00) begin
      idx = int'(addr[3:2]);
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      p.idx = idx;
      p.val = model[idx];
      pQ.push_back(p);
      bQ.push_back(2'b00);
    end else begin
      bQ.push_back(2'b10);
    end
  endtask

  function automatic rExp_t modelRead(input logic [5:0] addr);
    rExp_t e;
    if (addr[5:4] == 2'b00) begin
      e.data = model[int'(addr[3:2])];
      e.resp = 2'b00;
    end else begin
      e.data = 32'h0;
      e.resp = 2'b10;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int awDelay, input int wDelay, input int bHold);
    logic [1:0] expResp;
    bit seen;
    modelWrite(addr, data, strb);
    expResp = bQ[$];
    @(posedge clk); #1;
    fork
      begin
        bit awSeen;
        awSeen = 0;
        for (int i = 0; i < awDelay; i++) begin @(posedge clk); #1; end
        axi.S_AXI_AWADDR  = addr;
        axi.S_AXI_AWVALID = 1'b1;
        for (int c = 0; c < 50 && !awSeen; c++) begin
          @(negedge clk);
          if (axi.S_AXI_AWREADY) awSeen = 1;
        end
        @(posedge clk); #1;
        axi.S_AXI_AWVALID = 1'b0;
        if (!awSeen) checkOutput("AW handshake timeout", 32'd0, 32'd1);
      end
      begin
        bit wSeen;
        wSeen = 0;
        for (int i = 0; i < wDelay; i++) begin @(posedge clk); #1; end
        axi.S_AXI_WDATA  = data;
        axi.S_AXI_WSTRB  = strb;
        axi.S_AXI_WVALID = 1'b1;
        for (int c = 0; c < 50 && !wSeen; c++) begin
          @(negedge clk);
          if (axi.S_AXI_WREADY) wSeen = 1;
        end
        @(posedge clk); #1;
        axi.S_AXI_WVALID = 1'b0;
        if (!wSeen) checkOutput("W handshake timeout", 32'd0, 32'd1);
      end
    join
    @(negedge clk);
    checkOutput("BVALID before commit", 32'(axi.S_AXI_BVALID), 32'd0);
    checkOutput("AWREADY after capture", 32'(axi.S_AXI_AWREADY), 32'd0);
    checkOutput("WREADY after capture", 32'(axi.S_AXI_WREADY), 32'd0);
    @(negedge clk);
    checkOutput("BVALID latency", 32'(axi.S_AXI_BVALID), 32'd1);
    for (int i = 0; i < bHold; i++) begin
      @(negedge clk);
      checkOutput("BVALID held", 32'(axi.S_AXI_BVALID), 32'd1);
      checkOutput("BRESP held", 32'(axi.S_AXI_BRESP), 32'(expResp));
      checkOutput("AWREADY while B pending", 32'(axi.S_AXI_AWREADY), 32'd0);
      checkOutput("WREADY while B pending", 32'(axi.S_AXI_WREADY), 32'd0);
    end
    @(posedge clk); #1;
    axi.S_AXI_BREADY = 1'b1;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (axi.S_AXI_BVALID) seen = 1;
    end
    @(posedge clk); #1;
    axi.S_AXI_BREADY = 1'b0;
    if (!seen) checkOutput("B response timeout", 32'd0, 32'd1);
    @(negedge clk);
    checkOutput("AWREADY after B", 32'(axi.S_AXI_AWREADY), 32'd1);
    checkOutput("WREADY after B", 32'(axi.S_AXI_WREADY), 32'd1);
  endtask

  task automatic applyReadStimulus(input logic [5:0] addr, input int rHold);
    rExp_t e;
    bit seen;
    e = modelRead(addr);
    rQ.push_back(e);
    @(posedge clk); #1;
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (axi.S_AXI_ARREADY) seen = 1;
    end
    @(posedge clk); #1;
    axi.S_AXI_ARVALID = 1'b0;
    if (!seen) checkOutput("AR handshake timeout", 32'd0, 32'd1);
    @(negedge clk);
    checkOutput("RVALID latency", 32'(axi.S_AXI_RVALID), 32'd1);
    checkOutput("ARREADY after AR", 32'(axi.S_AXI_ARREADY), 32'd0);
    for (int i = 0; i < rHold; i++) begin
      @(negedge clk);
      checkOutput("RVALID held", 32'(axi.S_AXI_RVALID), 32'd1);
      checkOutput("RDATA held", axi.S_AXI_RDATA, e.data);
      checkOutput("ARREADY while R pending", 32'(axi.S_AXI_ARREADY), 32'd0);
    end
    @(posedge clk); #1;
    axi.S_AXI_RREADY = 1'b1;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (axi.S_AXI_RVALID) seen = 1;
    end
    @(posedge clk); #1;
    axi.S_AXI_RREADY = 1'b0;
    if (!seen) checkOutput("R response timeout", 32'd0, 32'd1);
    @(negedge clk);
    checkOutput("ARREADY after R", 32'(axi.S_AXI_ARREADY), 32'd1);
  endtask

  // Monitor: pops an expectation whenever the DUT completes a response or pulses.
  always @(negedge clk) begin
    if (rstN) begin
      if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
        if (bQ.size() == 0) begin
          checkOutput("unexpected B response", 32'd1, 32'd0);
        end else begin
          monB = bQ.pop_front();
          checkOutput("BRESP", 32'(axi.S_AXI_BRESP), 32'(monB));
        end
      end
      if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
        if (rQ.size() == 0) begin
          checkOutput("unexpected R response", 32'd1, 32'd0);
        end else begin
          monR = rQ.pop_front();
          checkOutput("RDATA", axi.S_AXI_RDATA, monR.data);
          checkOutput("RRESP", 32'(axi.S_AXI_RRESP), 32'(monR.resp));
        end
      end
      if (pulse != 4'b0000) begin
        if (pQ.size() == 0) begin
          checkOutput("unexpected reg_wr_pulse", 32'(pulse), 32'd0);
        end else begin
          monP = pQ.pop_front();
          checkOutput("reg_wr_pulse", 32'(pulse), 32'(4'b0001 << monP.idx));
          checkOutput("reg_out at pulse", regOut(monP.idx), monP.val);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit seen;
    logic [5:0]  rAddr;
    logic [31:0] rData;
    logic [3:0]  rStrb;

    rstN = 1'b0;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0;  axi.S_AXI_WSTRB = '0;  axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset AWREADY", 32'(axi.S_AXI_AWREADY), 32'd0);
    checkOutput("reset WREADY", 32'(axi.S_AXI_WREADY), 32'd0);
    checkOutput("reset ARREADY", 32'(axi.S_AXI_ARREADY), 32'd0);
    checkOutput("reset BVALID", 32'(axi.S_AXI_BVALID), 32'd0);
    checkOutput("reset RVALID", 32'(axi.S_AXI_RVALID), 32'd0);
    checkOutput("reset BRESP", 32'(axi.S_AXI_BRESP), 32'd0);
    checkOutput("reset RRESP", 32'(axi.S_AXI_RRESP), 32'd0);
    checkOutput("reset RDATA", axi.S_AXI_RDATA, 32'd0);
    checkOutput("reset pulse", 32'(pulse), 32'd0);
    checkRegs("reset");
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("AWREADY after release", 32'(axi.S_AXI_AWREADY), 32'd1);
    checkOutput("WREADY after release", 32'(axi.S_AXI_WREADY), 32'd1);
    checkOutput("ARREADY after release", 32'(axi.S_AXI_ARREADY), 32'd1);

    $display("[TB] basic write/readback");
    applyStimulus(6'h00, 32'h0101FFFF, 4'hF, 0, 0, 0); applyReadStimulus(6'h00, 0);
    applyStimulus(6'h04, 32'hABCD0001, 4'hF, 0, 0, 0); applyReadStimulus(6'h04, 0);
    applyStimulus(6'h08, 32'hDEAD0011, 4'hF, 0, 0, 0); applyReadStimulus(6'h08, 0);
    applyStimulus(6'h0C, 32'hBEEF0011, 4'hF, 0, 0, 0); applyReadStimulus(6'h0C, 0);
    checkOutput("reg0 written", reg0, 32'h0101FFFF);
    checkOutput("reg1 written", reg1, 32'hABCD0001);
    checkOutput("reg2 written", reg2, 32'hDEAD0011);
    checkOutput("reg3 written", reg3, 32'hBEEF0011);

    $display("[TB] AW leads W by 3 cycles");
    applyStimulus(6'h08, 32'h12345678, 4'hF, 0, 3, 0);
    checkOutput("reg2 late W", reg2, 32'h12345678);
    applyStimulus(6'h0C, 32'hCAFEF00D, 4'hF, 2, 0, 0);
    checkOutput("reg3 late AW", reg3, 32'hCAFEF00D);

    $display("[TB] byte strobes");
    applyStimulus(6'h04, 32'hABCD0001, 4'hF, 0, 0, 0);
    applyStimulus(6'h04, 32'hFFFFFFFF, 4'b0101, 1, 0, 0);
    applyReadStimulus(6'h04, 0);
    checkOutput("reg1 strobe merge", reg1, 32'hABFF00FF);
    applyStimulus(6'h00, 32'h55555555, 4'b0000, 0, 0, 0);
    checkOutput("reg0 zero strobe", reg0, 32'h0101FFFF);

    $display("[TB] out-of-range access");
    applyStimulus(6'h10, 32'h99999999, 4'hF, 0, 0, 0);
    applyReadStimulus(6'h14, 0);
    checkRegs("after SLVERR");

    $display("[TB] response backpressure");
    applyStimulus(6'h0C, 32'h0BADBEEF, 4'hF, 0, 0, 5);
    applyReadStimulus(6'h0C, 5);
    applyStimulus(6'h3C, 32'h11111111, 4'hF, 0, 0, 5);

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      rAddr = {4'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
        rData = $urandom;
        rStrb = 4'($urandom);
        applyStimulus(rAddr, rData, rStrb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        applyReadStimulus(rAddr, $urandom_range(0, 3));
      end
    end
    checkRegs("after random");

    $display("[TB] reset with B pending");
    modelWrite(6'h00, 32'hDEAD0011, 4'hF);
    void'(bQ.pop_back());
    @(posedge clk); #1;
    axi.S_AXI_AWADDR = 6'h00; axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA = 32'hDEAD0011; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (axi.S_AXI_AWREADY && axi.S_AXI_WREADY) seen = 1;
    end
    @(posedge clk); #1;
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    if (!seen) checkOutput("reset-test handshake timeout", 32'd0, 32'd1);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (axi.S_AXI_BVALID) seen = 1;
    end
    if (!seen) checkOutput("reset-test BVALID timeout", 32'd0, 32'd1);
    @(posedge clk); #3;
    checkOutput("reg0 before reset", reg0, 32'hDEAD0011);
    rstN = 1'b0;
    #1;
    checkOutput("BVALID on reset", 32'(axi.S_AXI_BVALID), 32'd0);
    checkOutput("AWREADY on reset", 32'(axi.S_AXI_AWREADY), 32'd0);
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    checkRegs("on reset");
    bQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    axi.S_AXI_BREADY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("no B after reset", 32'(axi.S_AXI_BVALID), 32'd0);
    end
    @(posedge clk); #1;
    axi.S_AXI_BREADY = 1'b0;

    applyStimulus(6'h08, 32'h0F0F0F0F, 4'hF, 0, 1, 0);
    applyReadStimulus(6'h08, 1);
    checkRegs("final");

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("B queue drained", 32'(bQ.size()), 32'd0);
    checkOutput("R queue drained", 32'(rQ.size()), 32'd0);
    checkOutput("pulse queue drained", 32'(pQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
